count_display: RTL and testbench
================================

# count_display

Display back end for the up/down pushbutton counter. Accepts the counter's 7-bit unsigned value (0–127), converts it to three BCD digits with a sequential shift-and-add-3 engine, and drives a time-multiplexed, active-low, three-digit seven-segment display. It sits between the counter output and the board's segment and anode pins.

## Interface
- `REFRESH_DIV`, default 50000: `clk` cycles each digit is displayed before the scan advances; legal range ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `count_in`  in  7  counter value; asynchronous to `clk`, may change at any time.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `an`  out  3  digit enables, active-low, one-hot; `an[0]`=ones, `an[1]`=tens, `an[2]`=hundreds.
- `busy`  out  1  high while a conversion is in progress (SHIFT or COMMIT).

## Operation
- Input capture: `count_in` passes through two registers, `s1` then `s2`. The value is stable when `s1 == s2`.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE → SHIFT when stable and (`s2 != last`, or `first` is set):
  - load the shift register with `{12'b0, s2}`;
  - set `last <= s2`, clear `first`;
  - set `bitcnt <= 7`.
- SHIFT, once per cycle:
  - every BCD nibble ≥ 5 gets +3;
  - shift the whole 19-bit register left by 1;
  - `bitcnt` decrements;
  - after the 7th shift go to COMMIT.
- COMMIT: `disp_bcd` (12 bits) ← upper 12 bits of the shift register → IDLE.
- Changes on `count_in` during SHIFT/COMMIT are not sampled. The FSM re-evaluates on return to IDLE, so the final value is always displayed.
- Nibble width: hundreds digit is at most 1; values up to 127 never overflow 12 BCD bits.
- Scan:
  - `refcnt` counts 0..`REFRESH_DIV`-1.
  - On wrap, `digit` advances 0→1→2→0.
  - `an`/`seg` are registered from `digit` and `disp_bcd` every cycle.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - blank=1111111.

## Timing
- Reset values:
  - `seg`=7'h7F, `an`=3'b111, `busy`=0;
  - `disp_bcd`=0, `digit`=0, `refcnt`=0;
  - `last`=0, `first`=1, state IDLE, `s1`=`s2`=0.
- First cycle after reset: `an`=3'b110 with the ones digit of `disp_bcd` (0).
- `first` forces one conversion after reset, even when the value is 0.
- Conversion latency:
  - `count_in` changes before edge k and is held;
  - `s2` has the value at edge k+1; stable and FSM leaves IDLE at edge k+2;
  - SHIFT occupies edges k+3..k+9, COMMIT at edge k+10;
  - `disp_bcd` is valid after edge k+10; `busy` is high during edges k+3..k+10.
- A new digit value appears on `seg` at the next scan register update, i.e. one cycle after `disp_bcd`.
- Each digit is displayed for exactly `REFRESH_DIV` cycles; full frame = 3×`REFRESH_DIV` cycles.
- Reset mid-conversion:
  - aborts to IDLE and restores all reset values;
  - the next stable value is converted because `first`=1.
- Metastable or multi-bit skew on `count_in` is rejected by the `s1 == s2` stability check.

## Configuration
- Macro: `COUNT_DISPLAY_BLANK_EN`.
- Defined: leading-zero blanking.
  - Hundreds digit shows blank when it is 0.
  - Tens digit shows blank when hundreds and tens are both 0.
  - Ones digit is always shown.
  - `an` still scans all three positions.
- Undefined: all three digits are always decoded (e.g. 5 shows "005").

## Test plan
- Reset and scan:
  - Stimulus: `REFRESH_DIV`=4, reset, `count_in`=0.
  - Response: `an` sequences 110→101→011 every 4 cycles; `seg`=1000000 on all digits (blank undefined); one conversion occurs (`busy` pulses for 8 cycles).
- Latency:
  - Stimulus: `count_in`=127 held.
  - Response: `disp_bcd`=12'h127 exactly 10 edges after the change; digits show 1/2/7 (`seg` 1111001, 0100100, 1111000).
- Change during conversion:
  - Stimulus: `count_in` 42→43 while `busy`=1.
  - Response: display first shows 42, then 43 after a second conversion; final `disp_bcd`=12'h043.
- Wrap values:
  - Stimulus: 0→127 (down-count underflow), then 127→0.
  - Response: `disp_bcd` 12'h127 then 12'h000.
- Mid-conversion reset:
  - Stimulus: assert `rst` during SHIFT with `count_in`=99.
  - Response: outputs return to reset values; after release `disp_bcd`=12'h099.
- Blanking:
  - Stimulus: `COUNT_DISPLAY_BLANK_EN` defined, `count_in`=7.
  - Response: hundreds and tens `seg`=1111111, ones=1111000; with 105, tens shows 1000000.

Source files
------------

// File: rtl/count_display.sv
// Display back end: synchronises a 7-bit count, converts it to BCD with a sequential
// shift-and-add-3 engine and scans three active-low seven-segment digits.
// Optional leading-zero blanking via `COUNT_DISPLAY_BLANK_EN.
module count_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] count_in,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t        state;
    logic [6:0]    s1;
    logic [6:0]    s2;
    logic [6:0]    last;
    logic          first;
    logic [2:0]    bitcnt;
    logic [18:0]   sr;
    logic [18:0]   sr_adj;
    logic [11:0]   disp_bcd;
    logic [RW-1:0] refcnt;
    logic [1:0]    digit;
    logic [3:0]    nib_c;
    logic          blank_c;
    logic [6:0]    seg_c;
    logic [2:0]    an_c;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Layout: [18:15] hundreds, [14:11] tens, [10:7] ones, [6:0] binary remainder
    always_comb begin
        sr_adj = {add3(sr[18:15]), add3(sr[14:11]), add3(sr[10:7]), sr[6:0]};
    end

    // Input synchroniser and conversion FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 7'd0;
            s2       <= 7'd0;
            last     <= 7'd0;
            first    <= 1'b1;
            state    <= IDLE;
            bitcnt   <= 3'd0;
            sr       <= 19'd0;
            disp_bcd <= 12'd0;
            busy     <= 1'b0;
        end else begin
            s1 <= count_in;
            s2 <= s1;
            case (state)
                IDLE: begin
                    if ((s1 == s2) && ((s2 != last) || first)) begin
                        sr     <= {12'd0, s2};
                        last   <= s2;
                        first  <= 1'b0;
                        bitcnt <= 3'd7;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr     <= sr_adj << 1;
                    bitcnt <= bitcnt - 3'd1;
                    if (bitcnt == 3'd1) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_bcd <= sr[18:7];
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Digit select and segment decode for the current scan position
    always_comb begin
        an_c    = 3'b111;
        nib_c   = 4'd0;
        blank_c = 1'b0;
        case (digit)
            2'd0: begin
                an_c  = 3'b110;
                nib_c = disp_bcd[3:0];
            end
            2'd1: begin
                an_c  = 3'b101;
                nib_c = disp_bcd[7:4];
`ifdef COUNT_DISPLAY_BLANK_EN
                blank_c = (disp_bcd[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                an_c  = 3'b011;
                nib_c = disp_bcd[11:8];
`ifdef COUNT_DISPLAY_BLANK_EN
                blank_c = (disp_bcd[11:8] == 4'd0);
`endif
            end
            default: blank_c = 1'b1;
        endcase
        seg_c = blank_c ? 7'b1111111 : decode(nib_c);
    end

    // Refresh divider, scan position and registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            refcnt <= '0;
            digit  <= 2'd0;
            an     <= 3'b111;
            seg    <= 7'h7F;
        end else begin
            if (refcnt == REF_MAX) begin
                refcnt <= '0;
                digit  <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
            end else begin
                refcnt <= refcnt + RW'(1);
            end
            an  <= an_c;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: scoreboard of expected BCD commits plus
// scan/segment checks, latency, mid-conversion change, wrap values and mid-conversion reset.
module tb_count_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] count_in;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [11:0] sb[$];
    logic prev_busy = 1'b0;

    count_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] bcd, input int pos);
`ifdef COUNT_DISPLAY_BLANK_EN
        if (pos == 2 && bcd[11:8] == 4'd0) return 7'b1111111;
        if (pos == 1 && bcd[11:4] == 8'd0) return 7'b1111111;
`endif
        case (pos)
            0:       return dec7(bcd[3:0]);
            1:       return dec7(bcd[7:4]);
            default: return dec7(bcd[11:8]);
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Scoreboard: every completed conversion must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && prev_busy === 1'b1 && busy === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL commit_unexpected: disp_bcd=%h, no conversion expected", dut.disp_bcd);
                end else begin
                    if (dut.disp_bcd !== sb[0]) begin
                        errors++;
                        $display("FAIL commit_value: disp_bcd=%h expected %h", dut.disp_bcd, sb[0]);
                    end
                    sb.delete(0);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_frame(output logic [6:0] f0, output logic [6:0] f1,
                                 output logic [6:0] f2, output bit bad);
        logic [2:0] seen;
        seen = 3'b000;
        bad  = 1'b0;
        f0   = 7'h00;
        f1   = 7'h00;
        f2   = 7'h00;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            case (an)
                3'b110:  begin f0 = seg; seen[0] = 1'b1; end
                3'b101:  begin f1 = seg; seen[1] = 1'b1; end
                3'b011:  begin f2 = seg; seen[2] = 1'b1; end
                default: bad = 1'b1;
            endcase
        end
        if (seen != 3'b111) bad = 1'b1;
    endtask

    task automatic test_reset;
        int busy_cnt;
        int pos;
        logic [2:0] exp_an;
        bit ok;
        rst = 1'b1;
        count_in = 7'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({seg, an, busy} !== {7'h7F, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: seg=%b an=%b busy=%b expected 1111111 111 0", seg, an, busy);
        end
        checks++;
        if (dut.disp_bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_disp_bcd: got %h expected 000", dut.disp_bcd);
        end
        sb.push_back(12'h000);
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            pos = (i / int'(DIV)) % 3;
            exp_an = ~(3'b001 << pos);
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("FAIL scan_an[%0d]: got %b expected %b", i, an, exp_an);
            end
            checks++;
            if (seg !== exp_seg(12'h000, pos)) begin
                errors++;
                $display("FAIL scan_seg[%0d]: got %b expected %b", i, seg, exp_seg(12'h000, pos));
            end
            if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL reset_busy_pulse: got %0d cycles expected 8", busy_cnt);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_drain: timeout, pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_latency;
        int busy_cnt;
        bit ok;
        bit bad;
        logic [6:0] f0, f1, f2;
        count_in = 7'd127;
        sb.push_back(12'h127);
        busy_cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (i == 10) begin
                checks++;
                if (dut.disp_bcd !== 12'h000) begin
                    errors++;
                    $display("FAIL latency_early: disp_bcd=%h after edge k+9 expected 000", dut.disp_bcd);
                end
            end
            if (i == 11) begin
                checks++;
                if (dut.disp_bcd !== 12'h127) begin
                    errors++;
                    $display("FAIL latency_k10: disp_bcd=%h after edge k+10 expected 127", dut.disp_bcd);
                end
            end
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL latency_busy: got %0d cycles expected 8", busy_cnt);
        end
        wait_drain(ok);
        @(negedge clk);
        capture_frame(f0, f1, f2, bad);
        checks++;
        if (!ok || bad || f0 !== exp_seg(12'h127, 0) || f1 !== exp_seg(12'h127, 1) || f2 !== exp_seg(12'h127, 2)) begin
            errors++;
            $display("FAIL digits_127: got %b/%b/%b ok=%0d bad=%0d expected %b/%b/%b",
                     f2, f1, f0, ok, bad, exp_seg(12'h127, 2), exp_seg(12'h127, 1), exp_seg(12'h127, 0));
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit bad;
        logic [6:0] f0, f1, f2;
        count_in = 7'd99;
        sb.push_back(12'h099);
        wait_busy(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: busy=%b ok=%0d expected busy 1", busy, ok);
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({seg, an, busy} !== {7'h7F, 3'b111, 1'b0} || dut.disp_bcd !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: seg=%b an=%b busy=%b bcd=%h expected 1111111 111 0 000",
                     seg, an, busy, dut.disp_bcd);
        end
        @(negedge clk);
        // Synchroniser restarts at zero with first set, so 0 converts before 99
        sb.push_back(12'h000);
        sb.push_back(12'h099);
        rst = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || dut.disp_bcd !== 12'h099) begin
            errors++;
            $display("FAIL midreset_final: disp_bcd=%h ok=%0d expected 099", dut.disp_bcd, ok);
        end
        @(negedge clk);
        capture_frame(f0, f1, f2, bad);
        checks++;
        if (bad || f0 !== exp_seg(12'h099, 0) || f1 !== exp_seg(12'h099, 1) || f2 !== exp_seg(12'h099, 2)) begin
            errors++;
            $display("FAIL digits_099: got %b/%b/%b bad=%0d expected %b/%b/%b",
                     f2, f1, f0, bad, exp_seg(12'h099, 2), exp_seg(12'h099, 1), exp_seg(12'h099, 0));
        end
    endtask

    task automatic test_change_during;
        bit ok;
        bit bad;
        logic [6:0] f0, f1, f2;
        count_in = 7'd42;
        sb.push_back(12'h042);
        wait_busy(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL change_busy: busy=%b expected 1 within bound", busy);
        end
        count_in = 7'd43;
        sb.push_back(12'h043);
        wait_drain(ok);
        checks++;
        if (!ok || dut.disp_bcd !== 12'h043) begin
            errors++;
            $display("FAIL change_final: disp_bcd=%h ok=%0d expected 043", dut.disp_bcd, ok);
        end
        @(negedge clk);
        capture_frame(f0, f1, f2, bad);
        checks++;
        if (bad || f0 !== exp_seg(12'h043, 0) || f1 !== exp_seg(12'h043, 1) || f2 !== exp_seg(12'h043, 2)) begin
            errors++;
            $display("FAIL digits_043: got %b/%b/%b bad=%0d expected %b/%b/%b",
                     f2, f1, f0, bad, exp_seg(12'h043, 2), exp_seg(12'h043, 1), exp_seg(12'h043, 0));
        end
    endtask

    task automatic test_wrap;
        int vals[3];
        bit ok;
        vals = '{0, 127, 0};
        foreach (vals[k]) begin
            count_in = 7'(vals[k]);
            sb.push_back(to_bcd(vals[k]));
            wait_drain(ok);
            checks++;
            if (!ok || dut.disp_bcd !== to_bcd(vals[k])) begin
                errors++;
                $display("FAIL wrap[%0d]: disp_bcd=%h ok=%0d expected %h", k, dut.disp_bcd, ok, to_bcd(vals[k]));
            end
        end
    endtask

    task automatic test_blank;
        int vals[2];
        bit ok;
        bit bad;
        logic [6:0] f0, f1, f2;
        logic [11:0] b;
        vals = '{7, 105};
        foreach (vals[k]) begin
            count_in = 7'(vals[k]);
            b = to_bcd(vals[k]);
            sb.push_back(b);
            wait_drain(ok);
            @(negedge clk);
            capture_frame(f0, f1, f2, bad);
            checks++;
            if (!ok || bad || f0 !== exp_seg(b, 0) || f1 !== exp_seg(b, 1) || f2 !== exp_seg(b, 2)) begin
                errors++;
                $display("FAIL blank_digits[%0d]: got %b/%b/%b ok=%0d bad=%0d expected %b/%b/%b",
                         vals[k], f2, f1, f0, ok, bad, exp_seg(b, 2), exp_seg(b, 1), exp_seg(b, 0));
            end
        end
    endtask

    task automatic test_back_to_back;
        int v;
        int prev;
        bit ok;
        prev = 105;
        for (int n = 0; n < 6; n++) begin
            v = int'($urandom_range(0, 127));
            if (v == prev) v = (v + 1) % 128;
            count_in = 7'(v);
            sb.push_back(to_bcd(v));
            wait_drain(ok);
            checks++;
            if (!ok || dut.disp_bcd !== to_bcd(v)) begin
                errors++;
                $display("FAIL random[%0d]: disp_bcd=%h ok=%0d expected %h", v, dut.disp_bcd, ok, to_bcd(v));
            end
            prev = v;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_reset_mid();
        test_change_during();
        test_wrap();
        test_blank();
        test_back_to_back();
        repeat (20) @(negedge clk);
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL final_idle: pending=%0d busy=%b expected 0 0", sb.size(), busy);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
